// File: rtl/game_pkg.sv
// Shared constants and types for the PS/2 keyboard path feeding the game-state FSM.
// The optional PS/2 clock glitch filter is enabled with the PS2_GLITCH_FILTER_EN macro.
package game_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam logic [7:0] KEY_SPACE      = 8'h29;
    localparam logic [7:0] START_CODE     = KEY_SPACE;

    // 2 ms at 50 MHz between PS/2 falling edges inside a frame.
    localparam int PS2_TIMEOUT_CYCLES = 100000;
    localparam int PS2_FILTER_CYCLES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Pin/event bundle between the PS/2 keyboard side and the key decoder.
// Optional glitch filter in the receiver is selected with PS2_GLITCH_FILTER_EN.
interface ps2_key_decoder_if;
    import game_pkg::*;

    // key_valid and frame_error are single-cycle pulses with no ready: a PS/2
    // keyboard cannot be stalled, so the consumer must take every pulse.
    // key_released/key_extended/last_key_received qualify key_valid.
    logic         PS2_CLK;
    logic         PS2_DAT;
    logic [7:0]   last_key_received;
    logic         key_extended;
    logic         key_valid;
    logic         key_released;
    logic         start_key;
    logic         frame_error;
    frame_state_t frame_state;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  last_key_received, key_extended, key_valid, key_released,
        input  start_key, frame_error, frame_state
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output last_key_received, key_extended, key_valid, key_released,
        output start_key, frame_error, frame_state
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, falling-edge detect (optionally glitch filtered
// via PS2_GLITCH_FILTER_EN), 11-bit frame FSM with odd parity and idle timeout.
module ps2_frame_rx
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         ps2_clk,
    input  logic         ps2_dat,
    output logic [7:0]   byte_data,
    output logic         byte_strobe,
    output logic         frame_error,
    output frame_state_t frame_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      dat_sync_q, dat_sync_d;
    logic            clk_prev_q, clk_prev_d;
    frame_state_t    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic            frame_error_q, frame_error_d;
    logic            fall_raw;
    logic            fall;
    logic            dat;

    assign fall_raw = clk_prev_q & ~clk_sync_q[1];
    assign dat      = dat_sync_q[1];

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(PS2_FILTER_CYCLES + 1);
    logic [FW-1:0] high_cnt_q, high_cnt_d;

    // Counts consecutive synced-high clocks up to the window; the fall is judged
    // against the count before it, so no latency is added.
    always_comb begin
        high_cnt_d = high_cnt_q;
        if (!clk_sync_q[1])
            high_cnt_d = '0;
        else if (high_cnt_q != FW'(PS2_FILTER_CYCLES))
            high_cnt_d = high_cnt_q + FW'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) high_cnt_q <= '0;
        else         high_cnt_q <= high_cnt_d;
    end

    assign fall = fall_raw && (high_cnt_q == FW'(PS2_FILTER_CYCLES));
`else
    assign fall = fall_raw;
`endif

    always_comb begin
        clk_sync_d    = {clk_sync_q[0], ps2_clk};
        dat_sync_d    = {dat_sync_q[0], ps2_dat};
        clk_prev_d    = clk_sync_q[1];
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        timeout_d     = timeout_q;
        frame_error_d = 1'b0;
        byte_strobe   = 1'b0;

        if (fall) begin
            // An edge always wins over a simultaneous timeout expiry.
            timeout_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = dat;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (dat && (^{shift_q, parity_q}))
                        byte_strobe = 1'b1;
                    else
                        frame_error_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timeout_q == TO_W'(TIMEOUT_CYCLES)) begin
                frame_error_d = 1'b1;
                shift_d       = '0;
                timeout_d     = '0;
                state_d       = ST_IDLE;
            end else begin
                timeout_d = timeout_q + TO_W'(1);
            end
        end else begin
            timeout_d = '0;
        end
    end

    // Sync flops reset high (PS/2 idle level) so reset release never looks like an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q    <= 2'b11;
            dat_sync_q    <= 2'b11;
            clk_prev_q    <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            timeout_q     <= '0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            dat_sync_q    <= dat_sync_d;
            clk_prev_q    <= clk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            timeout_q     <= timeout_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign byte_data   = shift_q;
    assign frame_error = frame_error_q;
    assign frame_state = state_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code decode layer: folds E0/F0 prefixes into flags, emits key events and
// the start_key level. Receiver glitch filter is selected with PS2_GLITCH_FILTER_EN.
module ps2_key_decoder
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic               clock,
    input  logic               resetn,
    ps2_key_decoder_if.slave   bus
);

    logic [7:0] byte_data;
    logic       byte_strobe;
    logic       rx_frame_error;

    logic       ext_pending_q, ext_pending_d;
    logic       brk_pending_q, brk_pending_d;
    logic [7:0] last_key_q, last_key_d;
    logic       key_ext_q, key_ext_d;
    logic       key_valid_q, key_valid_d;
    logic       key_rel_q, key_rel_d;
    logic       start_key_q, start_key_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk     (bus.PS2_CLK),
        .ps2_dat     (bus.PS2_DAT),
        .byte_data   (byte_data),
        .byte_strobe (byte_strobe),
        .frame_error (rx_frame_error),
        .frame_state (bus.frame_state)
    );

    always_comb begin
        ext_pending_d = ext_pending_q;
        brk_pending_d = brk_pending_q;
        last_key_d    = last_key_q;
        key_ext_d     = key_ext_q;
        key_valid_d   = 1'b0;
        key_rel_d     = key_rel_q;
        start_key_d   = start_key_q;

        if (rx_frame_error) begin
            ext_pending_d = 1'b0;
            brk_pending_d = 1'b0;
        end else if (byte_strobe) begin
            if (byte_data == PS2_EXT_PREFIX) begin
                ext_pending_d = 1'b1;
            end else if (byte_data == PS2_BRK_PREFIX) begin
                brk_pending_d = 1'b1;
            end else begin
                key_valid_d   = 1'b1;
                key_rel_d     = brk_pending_q;
                key_ext_d     = ext_pending_q;
                if (!brk_pending_q) last_key_d = byte_data;
                // Only the non-extended start code drives the level; typematic makes keep it high.
                if (!ext_pending_q && byte_data == START_CODE)
                    start_key_d = !brk_pending_q;
                ext_pending_d = 1'b0;
                brk_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
            last_key_q    <= '0;
            key_ext_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            key_rel_q     <= 1'b0;
            start_key_q   <= 1'b0;
        end else begin
            ext_pending_q <= ext_pending_d;
            brk_pending_q <= brk_pending_d;
            last_key_q    <= last_key_d;
            key_ext_q     <= key_ext_d;
            key_valid_q   <= key_valid_d;
            key_rel_q     <= key_rel_d;
            start_key_q   <= start_key_d;
        end
    end

    assign bus.last_key_received = last_key_q;
    assign bus.key_extended      = key_ext_q;
    assign bus.key_valid         = key_valid_q;
    assign bus.key_released      = key_rel_q;
    assign bus.start_key         = start_key_q;
    assign bus.frame_error       = rx_frame_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a PS/2 keyboard driver pushes expected
// events into a queue, a monitor pops and compares on every key_valid/frame_error.
module tb_ps2_key_decoder;
  import game_pkg::*;

  localparam int TO = 400;

  // clock / reset
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  // {err, released, extended, start_key, key[7:0]}
  logic [11:0] exp_q[$];

  function automatic logic [11:0] ev(input logic err, input logic rel, input logic ext,
                                     input logic start, input logic [7:0] key);
    return {err, rel, ext, start, key};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic ps2_bit(input logic b);
    bus.PS2_DAT = b;
    repeat (5) @(posedge clock);
    bus.PS2_CLK = 1'b0;
    repeat (10) @(posedge clock);
    bus.PS2_CLK = 1'b1;
    repeat (5) @(posedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip_par);
    ps2_bit(1'b1);
    repeat (10) @(posedge clock);
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic send_glitch_frame(input logic [7:0] d);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus.PS2_DAT = d[i];
        repeat (5) @(posedge clock);
        bus.PS2_CLK = 1'b0;
        repeat (4) @(posedge clock);
        bus.PS2_CLK = 1'b1;
        repeat (3) @(posedge clock);
        bus.PS2_CLK = 1'b0;
        repeat (4) @(posedge clock);
        bus.PS2_CLK = 1'b1;
        repeat (5) @(posedge clock);
      end else begin
        ps2_bit(d[i]);
      end
    end
    ps2_bit(~^d);
    ps2_bit(1'b1);
    repeat (10) @(posedge clock);
  endtask
`endif

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clock);
    repeat (5) @(posedge clock);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [11:0] got, e, mask;
    if (resetn && (bus.key_valid || bus.frame_error)) begin
      got = {bus.frame_error, bus.key_released, bus.key_extended, bus.start_key,
             bus.last_key_received};
      check("pulse_overlap", 32'(bus.key_valid & bus.frame_error), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        mask = e[11] ? 12'h9FF : 12'hFFF;
        check("event", 32'(got & mask), 32'(e & mask));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    resetn = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_last_key", 32'(bus.last_key_received), 32'd0);
    check("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check("rst_key_released", 32'(bus.key_released), 32'd0);
    check("rst_key_extended", 32'(bus.key_extended), 32'd0);
    check("rst_start_key", 32'(bus.start_key), 32'd0);
    check("rst_frame_error", 32'(bus.frame_error), 32'd0);
    check("rst_state", 32'(bus.frame_state), 32'(ST_IDLE));
    resetn = 1'b1;
    repeat (20) @(posedge clock);

    // space make, then typematic repeat
    exp_q.push_back(ev(0, 0, 0, 1, 8'h29));
    send_frame(8'h29, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 8'h29));
    send_frame(8'h29, 1'b0);
    // space break
    exp_q.push_back(ev(0, 1, 0, 0, 8'h29));
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    // extended make
    exp_q.push_back(ev(0, 0, 1, 0, 8'h75));
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    // space make again, then extended break/make of 29 must not touch start_key
    exp_q.push_back(ev(0, 0, 0, 1, 8'h29));
    send_frame(8'h29, 1'b0);
    exp_q.push_back(ev(0, 1, 1, 1, 8'h29));
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    exp_q.push_back(ev(0, 0, 1, 1, 8'h29));
    send_frame(8'hE0, 1'b0);
    send_frame(8'h29, 1'b0);
    drain("drain_basic");

    // bad parity
    exp_q.push_back(ev(1, 0, 0, 1, 8'h29));
    send_frame(8'h1C, 1'b1);
    // partial frame then timeout, followed by a good frame
    exp_q.push_back(ev(1, 0, 0, 1, 8'h29));
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (TO + 50) @(posedge clock);
    exp_q.push_back(ev(0, 0, 0, 1, 8'h1C));
    send_frame(8'h1C, 1'b0);
    // an error discards a pending break prefix
    exp_q.push_back(ev(1, 0, 0, 1, 8'h1C));
    exp_q.push_back(ev(0, 0, 0, 1, 8'h29));
    send_frame(8'hF0, 1'b0);
    send_frame(8'h55, 1'b1);
    send_frame(8'h29, 1'b0);
    // start bit of 1 while idle
    exp_q.push_back(ev(1, 0, 0, 1, 8'h29));
    ps2_bit(1'b1);
    drain("drain_errors");

    // reset after 6 bits of a 0x29 frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clock);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst_last_key", 32'(bus.last_key_received), 32'd0);
    check("midrst_start_key", 32'(bus.start_key), 32'd0);
    check("midrst_state", 32'(bus.frame_state), 32'(ST_IDLE));
    resetn = 1'b1;
    repeat (10) @(posedge clock);
    // leftover 1 is a start error; leftover 0 starts a frame that then times out
    exp_q.push_back(ev(1, 0, 0, 0, 8'h00));
    exp_q.push_back(ev(1, 0, 0, 0, 8'h00));
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TO + 50) @(posedge clock);
    drain("drain_reset");

`ifdef PS2_GLITCH_FILTER_EN
    exp_q.push_back(ev(0, 0, 0, 1, 8'h29));
    send_glitch_frame(8'h29);
    drain("drain_glitch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

PS/2 keyboard receiver and scan-code decoder feeding the game-state FSM. Deserialises 11-bit PS/2 frames from the board's PS2_CLK/PS2_DAT pins, checks framing and odd parity, folds E0/F0 prefixes into flags, and produces `last_key_received` and the level `start_key` consumed by `fsm_game_state`. It sits directly upstream of the game-state FSM, in the `clock` domain.

## Interface
- `START_CODE`, 8'h29 (space); make code that drives `start_key`.
- `TIMEOUT_CYCLES`, 100000 (2 ms at 50 MHz); maximum idle clocks between PS/2 falling edges inside a frame.
- `FILTER_CYCLES`, 8; PS/2 clock stability window, used only with the glitch filter.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `PS2_CLK`  in  1  raw keyboard clock, asynchronous.
- `PS2_DAT`  in  1  raw keyboard data, asynchronous.
- `last_key_received`  out  8  last accepted make code (non-prefix byte).
- `key_extended`  out  1  last accepted event carried an E0 prefix.
- `key_valid`  out  1  one-cycle pulse per completed make or break event.
- `key_released`  out  1  qualifies `key_valid`: 1 = break event.
- `start_key`  out  1  level, high while `START_CODE` (non-extended) is held.
- `frame_error`  out  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
- Input sync: PS2_CLK and PS2_DAT each pass through 2 flops; a falling edge is declared when the synced clock goes 1→0. Data is sampled on that edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge, if data = 0 → DATA, bit count = 0; if data = 1 → `frame_error`, stay IDLE.
  - DATA: shift data in LSB first; after bit 7 → PARITY.
  - PARITY: store bit → STOP.
  - STOP: on edge, if stop = 1 and the parity check passes (data ones + parity bit is odd) → byte accepted; otherwise → `frame_error`. Either way → IDLE.
- Timeout: a counter is cleared on every edge and runs in any state other than IDLE. On reaching `TIMEOUT_CYCLES` it pulses `frame_error`, clears the shifter and prefixes, and returns to IDLE.
- Decode layer, per accepted byte:
  - E0 sets `ext_pending`; no event.
  - F0 sets `brk_pending`; no event.
  - Any other byte:
    - Emit `key_valid`, with `key_released = brk_pending` and `key_extended = ext_pending`.
    - Update `last_key_received` only when `brk_pending` = 0.
    - Clear both pending flags.
- `start_key`:
  - Set on a make of `START_CODE` with `ext_pending` = 0.
  - Cleared on a break of `START_CODE` with `ext_pending` = 0.
  - Extended codes never touch it.
  - Repeated makes (typematic) keep it high; a repeated make also re-pulses `key_valid`.
- A `frame_error` discards any pending prefixes.
- Output width rules: all outputs are registered; the shifter is exactly 8 bits; the bit counter is 3 bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Reset: every output is 0, the FSM is in IDLE, the counters and pending flags are 0.
- resetn asserted mid-frame aborts immediately. After release, the FSM waits in IDLE; a partial frame in flight yields a start or stop `frame_error` and no event.
- Latency: `key_valid`, `key_released`, `key_extended`, `last_key_received` and `start_key` all update together, 1 clock after the clock in which the stop-bit edge is detected. That edge is detected 3 clocks after the raw PS2_CLK falls.
- `key_valid` and `frame_error` are single-cycle and never asserted together.
- A timeout expiring in the same cycle as an edge: the edge wins and the counter clears.

## Configuration
- `PS2_GLITCH_FILTER_EN` defined:
  - A falling edge counts only if synced PS2_CLK was high for ≥`FILTER_CYCLES` consecutive clocks before the fall.
  - Shorter highs are ignored.
  - Edge detection gains no extra latency.
- Undefined: raw synced-edge detection; `FILTER_CYCLES` is unused.

## Structure
- Shared package `game_pkg`:
  - Constants `PS2_EXT_PREFIX` = 8'hE0, `PS2_BRK_PREFIX` = 8'hF0, `KEY_SPACE` = 8'h29.
  - The frame-state enum.
- One sub-module, `ps2_frame_rx`: sync, edge/filter, frame FSM and timeout. It outputs `byte_data[7:0]`, `byte_strobe` and `frame_error`.
- The decode layer lives in `ps2_key_decoder`.

## Test plan
- Frame 0x29, parity 0 → `key_valid` pulse, `last_key_received` = 8'h29, `key_released` = 0, `start_key` = 1.
- F0 (parity 1) then 29 (parity 0) → one `key_valid` with `key_released` = 1, `last_key_received` stays 29, `start_key` = 0.
- E0 (parity 0) then 75 (parity 0) → `key_extended` = 1, `last_key_received` = 8'h75, `start_key` unchanged.
- 0x1C sent with parity 1 → `frame_error` pulse, no `key_valid`, `last_key_received` unchanged.
- 4 data bits then no clocks for 100000 cycles → `frame_error`; the next good 0x1C frame decodes correctly.
- resetn pulsed low after 6 bits of a 0x29 frame → outputs 0; the remaining bits cause no `key_valid`. With `PS2_GLITCH_FILTER_EN`, a 3-cycle PS2_CLK high glitch inside a frame is ignored and the frame still decodes to 0x29.
